// File: rtl/cmt_pkg.sv
// Shared constants and elaboration-time helpers for the clock generator.
// No logic, no latency, no backpressure.
package cmt_pkg;

  localparam int DEF_DIV1        = 2;
  localparam int DEF_DIV2        = 4;
  localparam int DEF_DIV3        = 10;
  localparam int DEF_LOCK_CYCLES = 16;

  localparam int DIV_MIN  = 2;
  localparam int DIV_MAX  = 256;
  localparam int LOCK_MIN = 1;
  localparam int LOCK_MAX = 65535;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  // Number of input cycles a divided clock spends high per period.
  function automatic int high_cycles(input int div);
    return div / 2;
  endfunction

endpackage

// File: rtl/cmt_div_channel.sv
// Integer clock divider: registered output high for floor(DIV/2) cycles, then low.
// Output follows the counter by one input edge; no backpressure (free-running).
module cmt_div_channel
  import cmt_pkg::*;
#(
  parameter int DIV = DEF_DIV1
) (
  input  logic CLK_IN1,
  input  logic RESET,
  output logic clk_out
);

  localparam int            W      = clog2_min1(DIV);
  localparam int            HIGH   = high_cycles(DIV);
  localparam logic [W-1:0]  LAST   = W'(DIV - 1);
  localparam logic [W:0]    HIGH_W = (W + 1)'(HIGH);

  logic [W-1:0] cnt;

  // Compare uses the pre-edge count so the first edge after reset drives the output high.
  always_ff @(posedge CLK_IN1 or posedge RESET) begin
    if (RESET) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else begin
      cnt     <= (cnt == LAST) ? '0 : cnt + W'(1);
      clk_out <= ({1'b0, cnt} < HIGH_W);
    end
  end

endmodule

// File: rtl/cmt_clock_gen.sv
// Three phase-aligned divided clocks from CLK_IN1 plus a sticky LOCKED flag.
// Outputs registered one edge after the counters; free-running, no backpressure.
module cmt_clock_gen
  import cmt_pkg::*;
#(
  parameter int DIV1        = DEF_DIV1,
  parameter int DIV2        = DEF_DIV2,
  parameter int DIV3        = DEF_DIV3,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic CLK_IN1,
  input  logic RESET,
  output logic CLK_OUT1,
  output logic CLK_OUT2,
  output logic CLK_OUT3,
  output logic LOCKED
);

  if (DIV1 < DIV_MIN || DIV1 > DIV_MAX) begin : g_bad_div1
    $error("cmt_clock_gen: DIV1=%0d outside %0d..%0d", DIV1, DIV_MIN, DIV_MAX);
  end
  if (DIV2 < DIV_MIN || DIV2 > DIV_MAX) begin : g_bad_div2
    $error("cmt_clock_gen: DIV2=%0d outside %0d..%0d", DIV2, DIV_MIN, DIV_MAX);
  end
  if (DIV3 < DIV_MIN || DIV3 > DIV_MAX) begin : g_bad_div3
    $error("cmt_clock_gen: DIV3=%0d outside %0d..%0d", DIV3, DIV_MIN, DIV_MAX);
  end
  if (LOCK_CYCLES < LOCK_MIN || LOCK_CYCLES > LOCK_MAX) begin : g_bad_lock
    $error("cmt_clock_gen: LOCK_CYCLES=%0d outside %0d..%0d", LOCK_CYCLES, LOCK_MIN, LOCK_MAX);
  end

  cmt_div_channel #(.DIV(DIV1)) u_ch1 (.CLK_IN1(CLK_IN1), .RESET(RESET), .clk_out(CLK_OUT1));
  cmt_div_channel #(.DIV(DIV2)) u_ch2 (.CLK_IN1(CLK_IN1), .RESET(RESET), .clk_out(CLK_OUT2));
  cmt_div_channel #(.DIV(DIV3)) u_ch3 (.CLK_IN1(CLK_IN1), .RESET(RESET), .clk_out(CLK_OUT3));

  localparam int            LW       = clog2_min1(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_TGT = LW'(LOCK_CYCLES);

  logic [LW-1:0] lock_cnt;

  // Counter saturates at LOCK_TGT; LOCKED sets on the edge that reaches it and holds until reset.
  always_ff @(posedge CLK_IN1 or posedge RESET) begin
    if (RESET) begin
      lock_cnt <= '0;
      LOCKED   <= 1'b0;
    end else if (lock_cnt < LOCK_TGT) begin
      lock_cnt <= lock_cnt + LW'(1);
      if (lock_cnt == LOCK_TGT - LW'(1)) begin
        LOCKED <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmt_clock_gen.sv
// Directed bench for cmt_clock_gen: edge-count model checked every cycle plus literal pins.
`timescale 1ns/1ps
module tb_cmt_clock_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic a_o1, a_o2, a_o3, a_lk;
  logic b_o1, b_o2, b_o3, b_lk;
  logic c_o1, c_o2, c_o3, c_lk;

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  always #5 clk = ~clk;

  cmt_clock_gen dut_a (
    .CLK_IN1(clk), .RESET(rst),
    .CLK_OUT1(a_o1), .CLK_OUT2(a_o2), .CLK_OUT3(a_o3), .LOCKED(a_lk)
  );

  cmt_clock_gen #(.DIV3(5)) dut_b (
    .CLK_IN1(clk), .RESET(rst),
    .CLK_OUT1(b_o1), .CLK_OUT2(b_o2), .CLK_OUT3(b_o3), .LOCKED(b_lk)
  );

  cmt_clock_gen #(.DIV1(2), .DIV2(2), .DIV3(2), .LOCK_CYCLES(1)) dut_c (
    .CLK_IN1(clk), .RESET(rst),
    .CLK_OUT1(c_o1), .CLK_OUT2(c_o2), .CLK_OUT3(c_o3), .LOCKED(c_lk)
  );

  // Model state: number of rising edges seen since the last reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) k = 0;
    else     k = k + 1;
  end

  // After edge k (k>=1) a divide-by-div clock sits in input cycle (k-1) of its period.
  function automatic logic exp_clk(input int edges, input int div);
    if (edges == 0) return 1'b0;
    return ((edges - 1) % div) < (div / 2);
  endfunction

  function automatic logic exp_lock(input int edges, input int lc);
    return edges >= lc;
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("a_out1", a_o1, exp_clk(k, 2));
    chk("a_out2", a_o2, exp_clk(k, 4));
    chk("a_out3", a_o3, exp_clk(k, 10));
    chk("a_lock", a_lk, exp_lock(k, 16));
    chk("b_out1", b_o1, exp_clk(k, 2));
    chk("b_out2", b_o2, exp_clk(k, 4));
    chk("b_out3", b_o3, exp_clk(k, 5));
    chk("b_lock", b_lk, exp_lock(k, 16));
    chk("c_out1", c_o1, exp_clk(k, 2));
    chk("c_out2", c_o2, exp_clk(k, 2));
    chk("c_out3", c_o3, exp_clk(k, 2));
    chk("c_lock", c_lk, exp_lock(k, 1));
  end

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return a_o1;
      1:       return a_o2;
      2:       return a_o3;
      3:       return b_o3;
      default: return c_o1;
    endcase
  endfunction

  // Sampled on negedges: every output edge lands on a posedge, so sample-time deltas are exact.
  task automatic wait_level_change(input int sel, input logic val, input string nm, output bit ok);
    logic prev;
    logic cur;
    prev = get_sig(sel);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      cur = get_sig(sel);
      if (prev !== val && cur === val) begin
        ok = 1'b1;
        return;
      end
      prev = cur;
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s timeout at %0t: got no edge to %b expected one within 300 cycles", nm, $time, val);
  endtask

  task automatic measure(input int sel, input int per, input int hi, input string nm);
    time r0, f0, r1;
    bit  ok;
    wait_level_change(sel, 1'b1, nm, ok);
    if (!ok) return;
    r0 = $time;
    for (int p = 0; p < 10; p++) begin
      wait_level_change(sel, 1'b0, nm, ok);
      if (!ok) return;
      f0 = $time;
      wait_level_change(sel, 1'b1, nm, ok);
      if (!ok) return;
      r1 = $time;
      chk_int({nm, "_high_ns"},   int'(f0 - r0), hi);
      chk_int({nm, "_period_ns"}, int'(r1 - r0), per);
      r0 = r1;
    end
  endtask

  initial begin
    bit ok;

    // Reset held for 100 ns.
    #50;
    chk("rst_a_out1", a_o1, 1'b0);
    chk("rst_a_out2", a_o2, 1'b0);
    chk("rst_a_out3", a_o3, 1'b0);
    chk("rst_a_lock", a_lk, 1'b0);
    chk("rst_c_lock", c_lk, 1'b0);
    #50;
    rst = 1'b0;

    // First edge after release at 105 ns.
    @(posedge clk); #1;
    chk("first_a_out1", a_o1, 1'b1);
    chk("first_a_out2", a_o2, 1'b1);
    chk("first_a_out3", a_o3, 1'b1);
    chk("first_b_out3", b_o3, 1'b1);
    chk("first_a_lock", a_lk, 1'b0);
    chk("first_c_lock", c_lk, 1'b1);

    repeat (14) @(posedge clk);
    #1;
    chk("edge15_a_lock", a_lk, 1'b0);
    @(posedge clk); #1;
    chk("edge16_a_lock", a_lk, 1'b1);
    chk("edge16_a_out1", a_o1, 1'b0);
    chk("edge16_a_out3", a_o3, 1'b0);

    measure(0, 20,  10, "a_out1");
    measure(1, 40,  20, "a_out2");
    measure(2, 100, 50, "a_out3");
    measure(3, 50,  20, "b_out3");
    measure(4, 20,  10, "c_out1");

    #1000;
    chk("lock_held_a", a_lk, 1'b1);

    // Short asynchronous reset pulse inside the high phase of a_out3.
    wait_level_change(2, 1'b1, "a_out3_rise", ok);
    #1;
    chk("pre_pulse_a_out3", a_o3, 1'b1);
    rst = 1'b1;
    #1;
    chk("pulse_a_out1", a_o1, 1'b0);
    chk("pulse_a_out2", a_o2, 1'b0);
    chk("pulse_a_out3", a_o3, 1'b0);
    chk("pulse_a_lock", a_lk, 1'b0);
    chk("pulse_b_out3", b_o3, 1'b0);
    chk("pulse_c_lock", c_lk, 1'b0);
    #2;
    rst = 1'b0;

    @(posedge clk); #1;
    chk("realign_a_out1", a_o1, 1'b1);
    chk("realign_a_out2", a_o2, 1'b1);
    chk("realign_a_out3", a_o3, 1'b1);
    chk("realign_a_lock", a_lk, 1'b0);
    chk("realign_c_lock", c_lk, 1'b1);
    repeat (14) @(posedge clk);
    #1;
    chk("re_edge15_a_lock", a_lk, 1'b0);
    @(posedge clk); #1;
    chk("re_edge16_a_lock", a_lk, 1'b1);

    repeat (60) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
